// File: rtl/bcd_serial_addsub_ctrl.sv
// Digit-serial multi-digit BCD add/subtract sequencer, LSD-first.
// Optional: `BCD_SIGN_MAG_EN adds a FIX pass giving |A-B| plus a negative flag.
module bcd_serial_addsub_ctrl #(
    parameter int DIGITS = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              sub,
    input  logic [4*DIGITS-1:0] a,
    input  logic [4*DIGITS-1:0] b,
    output logic              busy,
    output logic              done,
    output logic [4*DIGITS-1:0] result,
    output logic              carry_out,
    output logic              negative,
    output logic              err
);

    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IW-1:0] LAST = IW'(DIGITS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
`ifdef BCD_SIGN_MAG_EN
        S_FIX  = 2'd2,
`endif
        S_DONE = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [DIGITS-1:0][3:0] a_q, b_q, res_q;
    logic [IW-1:0] idx_q;
    logic          sub_q, c_q, err_q, cout_q, done_q;
`ifdef BCD_SIGN_MAG_EN
    logic          neg_q;
`endif

    logic [3:0] op1, op2, r;
    logic [4:0] s, sm;
    logic       c_nxt, in_bad, last;

    assign last = (idx_q == LAST);

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic; a borrow with valid inputs detours through FIX
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: if (start) state_d = S_RUN;
            S_RUN: begin
                if (last) begin
`ifdef BCD_SIGN_MAG_EN
                    if (sub_q && !c_nxt && !err_q) state_d = S_FIX;
                    else                          state_d = S_DONE;
`else
                    state_d = S_DONE;
`endif
                end
            end
`ifdef BCD_SIGN_MAG_EN
            S_FIX: if (last) state_d = S_DONE;
`endif
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs: status, input digit check and the shared digit slice
    always_comb begin
        busy = (state_q == S_RUN);
`ifdef BCD_SIGN_MAG_EN
        busy = busy || (state_q == S_FIX);
`endif
        in_bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (a[4*i +: 4] > 4'd9) in_bad = 1'b1;
            if (b[4*i +: 4] > 4'd9) in_bad = 1'b1;
        end
        op1 = a_q[idx_q];
        op2 = sub_q ? (4'd9 - b_q[idx_q]) : b_q[idx_q];
`ifdef BCD_SIGN_MAG_EN
        if (state_q == S_FIX) begin
            op1 = 4'd9 - res_q[idx_q];
            op2 = 4'd0;
        end
`endif
        s  = {1'b0, op1} + {1'b0, op2} + {4'd0, c_q};
        sm = s - 5'd10;
        if (s > 5'd9) begin
            r     = sm[3:0];
            c_nxt = 1'b1;
        end else begin
            r     = s[3:0];
            c_nxt = 1'b0;
        end
    end

    // Datapath: operand capture, digit write-back, flags and done pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q    <= '0;
            b_q    <= '0;
            res_q  <= '0;
            idx_q  <= '0;
            sub_q  <= 1'b0;
            c_q    <= 1'b0;
            err_q  <= 1'b0;
            cout_q <= 1'b0;
            done_q <= 1'b0;
`ifdef BCD_SIGN_MAG_EN
            neg_q  <= 1'b0;
`endif
        end else begin
            done_q <= (state_q == S_DONE);
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        a_q    <= a;
                        b_q    <= b;
                        sub_q  <= sub;
                        c_q    <= sub;
                        idx_q  <= '0;
                        err_q  <= in_bad;
                        cout_q <= 1'b0;
                        res_q  <= '0;
`ifdef BCD_SIGN_MAG_EN
                        neg_q  <= 1'b0;
`endif
                    end
                end
                S_RUN: begin
                    if (!err_q) res_q[idx_q] <= r;
                    if (last) begin
                        cout_q <= err_q ? 1'b0 : c_nxt;
                        c_q    <= 1'b1;
                        idx_q  <= '0;
                    end else begin
                        c_q   <= c_nxt;
                        idx_q <= idx_q + 1'b1;
                    end
                end
`ifdef BCD_SIGN_MAG_EN
                S_FIX: begin
                    res_q[idx_q] <= r;
                    c_q          <= c_nxt;
                    neg_q        <= 1'b1;
                    if (last) idx_q <= '0;
                    else      idx_q <= idx_q + 1'b1;
                end
`endif
                default: ;
            endcase
        end
    end

    assign done      = done_q;
    assign result    = res_q;
    assign carry_out = cout_q;
    assign err       = err_q;
`ifdef BCD_SIGN_MAG_EN
    assign negative  = neg_q;
`else
    assign negative  = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_serial_addsub_ctrl.sv
// Directed self-checking bench for bcd_serial_addsub_ctrl (DIGITS=4).
module tb_bcd_serial_addsub_ctrl;

    logic        clk = 1'b0;
    logic        rst, start, sub;
    logic [15:0] a, b;
    logic        busy, done, carry_out, negative, err;
    logic [15:0] result;

    int nvec = 0;
    int nerr = 0;
    int lat;
    int dcnt;

    bcd_serial_addsub_ctrl #(.DIGITS(4)) dut (
        .clk(clk), .rst(rst), .start(start), .sub(sub),
        .a(a), .b(b), .busy(busy), .done(done),
        .result(result), .carry_out(carry_out),
        .negative(negative), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Launch one op; optionally pulse a stray start at cycle 'poke'.
    task automatic do_op(input logic s, input logic [15:0] x,
                         input logic [15:0] y, input int poke,
                         output int l);
        @(negedge clk);
        sub = s; a = x; b = y; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        l = 0;
        while (l < 40) begin
            @(posedge clk);
            l++;
            @(negedge clk);
            if (l == poke) begin
                start = 1'b1; sub = 1'b1;
                a = 16'h9999; b = 16'h1111;
            end else begin
                start = 1'b0;
            end
            if (done) break;
        end
        start = 1'b0;
        chk("done_seen", {31'd0, done}, 32'd1);
    endtask

    task automatic chk_tail(input string tag);
        @(negedge clk);
        chk({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
        chk({tag, "_idle"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_result", {16'd0, result}, 32'd0);
        chk("rst_flags", {29'd0, carry_out, negative, err}, 32'd0);
        rst = 1'b0;

        do_op(1'b0, 16'h1234, 16'h5678, -1, lat);
        chk("add1_lat", lat, 32'd5);
        chk("add1_res", {16'd0, result}, 32'h6912);
        chk("add1_cout", {31'd0, carry_out}, 32'd0);
        chk("add1_err", {31'd0, err}, 32'd0);
        chk_tail("add1");

        do_op(1'b0, 16'h9999, 16'h0001, -1, lat);
        chk("ovf_res", {16'd0, result}, 32'h0000);
        chk("ovf_cout", {31'd0, carry_out}, 32'd1);
        chk("ovf_err", {31'd0, err}, 32'd0);

        do_op(1'b1, 16'h5000, 16'h1234, -1, lat);
        chk("sub1_lat", lat, 32'd5);
        chk("sub1_res", {16'd0, result}, 32'h3766);
        chk("sub1_cout", {31'd0, carry_out}, 32'd1);
        chk("sub1_neg", {31'd0, negative}, 32'd0);

        do_op(1'b1, 16'h1234, 16'h5000, -1, lat);
`ifdef BCD_SIGN_MAG_EN
        chk("sub2_lat", lat, 32'd9);
        chk("sub2_res", {16'd0, result}, 32'h3766);
        chk("sub2_neg", {31'd0, negative}, 32'd1);
`else
        chk("sub2_lat", lat, 32'd5);
        chk("sub2_res", {16'd0, result}, 32'h6234);
        chk("sub2_neg", {31'd0, negative}, 32'd0);
`endif
        chk("sub2_cout", {31'd0, carry_out}, 32'd0);
        chk_tail("sub2");

        do_op(1'b1, 16'h1234, 16'h1234, -1, lat);
        chk("eq_res", {16'd0, result}, 32'h0000);
        chk("eq_cout", {31'd0, carry_out}, 32'd1);
        chk("eq_neg", {31'd0, negative}, 32'd0);

        do_op(1'b0, 16'h1234, 16'h5678, 2, lat);
        chk("ign_lat", lat, 32'd5);
        chk("ign_res", {16'd0, result}, 32'h6912);
        chk_tail("ign");

        @(negedge clk);
        sub = 1'b0; a = 16'h1111; b = 16'h2222; start = 1'b1;
        repeat (2) @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_res", {16'd0, result}, 32'h0000);
        chk("abort_flags", {29'd0, carry_out, negative, err}, 32'd0);
        dcnt = 0;
        repeat (10) begin
            @(negedge clk);
            if (done) dcnt++;
        end
        chk("abort_no_done", dcnt, 32'd0);

        @(negedge clk);
        rst = 1'b1; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        chk("rst_wins", {31'd0, busy}, 32'd0);

        do_op(1'b0, 16'h00A0, 16'h0001, -1, lat);
        chk("bad_lat", lat, 32'd5);
        chk("bad_err", {31'd0, err}, 32'd1);
        chk("bad_res", {16'd0, result}, 32'h0000);
        chk("bad_cout", {31'd0, carry_out}, 32'd0);
        chk("bad_neg", {31'd0, negative}, 32'd0);

        do_op(1'b0, 16'h0012, 16'h0034, -1, lat);
        chk("clr_err", {31'd0, err}, 32'd0);
        chk("clr_res", {16'd0, result}, 32'h0046);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
